lsu_ctrl: RTL
=============

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 64, sets the maximum WAIT cycles before abort; legal range 2..255.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  execute stage presents a memory operation.
REQ-005 req_ready  out  1  lsu_ctrl accepts the operation this cycle.
REQ-006 req_addr  in  64  byte address.
REQ-007 req_wdata  in  64  store data, right-aligned.
REQ-008 req_ctrl  in  4  operation code: loads 0000 LD8, 0001 LHU, 0010 LBU, 0011 LW(sext), 0100 LH(sext), 0101 LWU; stores 1000 SD, 1001 SW, 1010 SH, 1011 SB.
REQ-009 mem_req_valid  out  1  request to the memory stage.
REQ-010 mem_req_ready  in  1  memory stage accepts the request.
REQ-011 mem_addr  out  64  request address, equal to {addr[63:3],3'b000}.
REQ-012 mem_wen  out  1  1 = store, 0 = load.
REQ-013 mem_wdata  out  64  store data shifted to its byte lanes.
REQ-014 mem_wmask  out  8  byte-lane write enables; 0 for loads.
REQ-015 mem_resp_valid  in  1  load data or store acknowledge, one-cycle pulse.
REQ-016 mem_rdata  in  64  aligned 8-byte word; valid with mem_resp_valid.
REQ-017 rsp_valid  out  1  result available to writeback.
REQ-018 rsp_ready  in  1  writeback consumes the result.
REQ-019 rsp_rdata  out  64  extracted and extended load data; 0 for stores and errors.
REQ-020 rsp_err  out  2  result code: 00 ok, 01 misaligned, 10 timeout, 11 illegal ctrl.
REQ-021 busy  out  1  high in any state other than IDLE.

Function
REQ-022 The FSM SHALL have four states, IDLE, REQ, WAIT and RESP, and only one operation is in flight at a time.
REQ-023 In IDLE, req_ready SHALL be 1; in all other states it SHALL be 0.
REQ-024 When req_valid && req_ready, the block SHALL register addr, wdata and ctrl, and the registered values SHALL stay stable until the return to IDLE.
REQ-025 On acceptance, an illegal ctrl (0110, 0111, 11xx) SHALL go to RESP with err 11, and no memory request is issued.
REQ-026 On acceptance, a misaligned access SHALL go to RESP with err 01, and no memory request is issued.
- Misaligned means: size 8 with addr[2:0]≠0; size 4 with addr[1:0]≠0; size 2 with addr[0]≠0.
- Byte accesses are never misaligned.
REQ-027 Otherwise, acceptance SHALL go to REQ.
REQ-028 In REQ, mem_req_valid SHALL be 1, and mem_addr, mem_wen, mem_wdata and mem_wmask SHALL be held stable until mem_req_ready; at the handshake the FSM goes to WAIT.
REQ-029 Store lanes: mem_wdata SHALL equal req_wdata << (8*addr[2:0]), and mem_wmask SHALL equal the size mask (FF/0F/03/01) << addr[2:0].
REQ-030 In WAIT, a cycle counter SHALL start at 0 and increment each cycle.
- mem_resp_valid goes to RESP with err 00.
- If the counter reaches TIMEOUT-1 without a response, the FSM goes to RESP with err 10.
- mem_resp_valid on the same cycle as the timeout wins, and err is 00.
REQ-031 mem_resp_valid outside WAIT SHALL be ignored.
REQ-032 Load extraction SHALL select bytes from mem_rdata >> (8*addr[2:0]), then zero- or sign-extend per ctrl; stores and errors return rsp_rdata=0.
REQ-033 In RESP, rsp_valid SHALL be 1, with rsp_rdata and rsp_err held stable until rsp_ready; at the handshake the FSM goes to IDLE.
REQ-034 Minimum latency SHALL be: accept at cycle 0, mem_req_valid at cycle 1, mem_resp_valid at cycle 2 at the earliest, rsp_valid at cycle 3.
REQ-035 An error path SHALL present rsp_valid at cycle 1.
REQ-036 The mem_* outputs SHALL be registered, not combinationally derived from req_* inputs.

Reset
REQ-037 While rst_n=0, the state SHALL be IDLE and the following outputs SHALL be 0: mem_req_valid, mem_wen, mem_wmask, rsp_valid, rsp_err, rsp_rdata, busy, and the counter.
REQ-038 While rst_n=0, req_ready SHALL be 0.
REQ-039 Assertion of rst_n mid-operation SHALL abort the operation with no response.
REQ-040 Deassertion of rst_n SHALL take effect at the first clk edge after rst_n rises.

Verification
REQ-041 LW at 0x1004 with mem_rdata=0x8000_0001_xxxx_xxxx -> rsp_rdata=0xFFFF_FFFF_8000_0001, err 00, rsp_valid 3 cycles after accept.
REQ-042 SB at 0x2003 with wdata 0xAB -> mem_addr=0x2000, mem_wmask=0x08, mem_wdata[31:24]=0xAB, mem_wen=1, rsp_rdata=0.
REQ-043 LD8 at 0x3002 -> no mem_req_valid ever, rsp_err=01 at cycle 1; ctrl 0111 -> rsp_err=11 at cycle 1.
REQ-044 With TIMEOUT=4 and no mem_resp_valid -> rsp_err=10 exactly 4 WAIT cycles after the handshake; the next request is accepted after rsp_ready.
REQ-045 Backpressure: mem_req_ready low for 5 cycles and rsp_ready low for 3 cycles -> all outputs stable throughout, req_ready=0, exactly one response.
REQ-046 rst_n pulsed low during WAIT -> all outputs 0 immediately; a late mem_resp_valid is ignored; a fresh LBU then completes normally.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller between the execute and memory stages.
// Checks ctrl and alignment locally, steers store lanes, extends load data and aborts stalled WAITs.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [3:0]  req_ctrl,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  output logic        mem_wen,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [63:0] addr_q, wdata_q;
  logic [3:0]  ctrl_q;
  logic [7:0]  cnt;

  logic [3:0]  acc_size;
  logic        accept, acc_illegal, acc_misaligned, timeout_hit;
  logic [63:0] shifted_rdata, load_data;

  // Access size in bytes; 0 marks an illegal operation code.
  function automatic logic [3:0] op_size(input logic [3:0] c);
    case (c)
      4'b0000, 4'b1000:          op_size = 4'd8;
      4'b0011, 4'b0101, 4'b1001: op_size = 4'd4;
      4'b0001, 4'b0100, 4'b1010: op_size = 4'd2;
      4'b0010, 4'b1011:          op_size = 4'd1;
      default:                   op_size = 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] size_mask(input logic [3:0] s);
    case (s)
      4'd8:    size_mask = 8'hFF;
      4'd4:    size_mask = 8'h0F;
      4'd2:    size_mask = 8'h03;
      4'd1:    size_mask = 8'h01;
      default: size_mask = 8'h00;
    endcase
  endfunction

  assign accept         = req_valid && req_ready;
  assign acc_size       = op_size(req_ctrl);
  assign acc_illegal    = (acc_size == 4'd0);
  assign acc_misaligned = ((acc_size == 4'd8) && (req_addr[2:0] != 3'd0)) ||
                          ((acc_size == 4'd4) && (req_addr[1:0] != 2'd0)) ||
                          ((acc_size == 4'd2) && req_addr[0]);
  assign timeout_hit    = (cnt == 8'(TIMEOUT - 1));

  assign req_ready     = rst_n && (state == IDLE);
  assign busy          = (state != IDLE);
  assign mem_req_valid = (state == REQ);
  assign rsp_valid     = (state == RESP);

  // Memory-side fields come only from the captured operation, so they hold through backpressure.
  assign mem_addr  = {addr_q[63:3], 3'b000};
  assign mem_wen   = ctrl_q[3] && !ctrl_q[2];
  assign mem_wdata = mem_wen ? (wdata_q << {addr_q[2:0], 3'b000}) : 64'd0;
  assign mem_wmask = mem_wen ? (size_mask(op_size(ctrl_q)) << addr_q[2:0]) : 8'd0;

  assign shifted_rdata = mem_rdata >> {addr_q[2:0], 3'b000};

  always_comb begin
    load_data = 64'd0;
    case (ctrl_q)
      4'b0000: load_data = shifted_rdata;
      4'b0001: load_data = {48'd0, shifted_rdata[15:0]};
      4'b0010: load_data = {56'd0, shifted_rdata[7:0]};
      4'b0011: load_data = {{32{shifted_rdata[31]}}, shifted_rdata[31:0]};
      4'b0100: load_data = {{48{shifted_rdata[15]}}, shifted_rdata[15:0]};
      4'b0101: load_data = {32'd0, shifted_rdata[31:0]};
      default: load_data = 64'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (acc_illegal || acc_misaligned) ? RESP : REQ;
      REQ:     if (mem_req_ready) state_nxt = WAIT;
      WAIT:    if (mem_resp_valid || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A response arriving on the timeout cycle takes priority over the abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      ctrl_q    <= '0;
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            ctrl_q    <= req_ctrl;
            rsp_rdata <= '0;
            rsp_err   <= acc_illegal ? 2'b11 : (acc_misaligned ? 2'b01 : 2'b00);
          end
        end
        REQ: begin
          if (mem_req_ready) cnt <= '0;
        end
        WAIT: begin
          cnt <= cnt + 8'd1;
          if (mem_resp_valid) begin
            rsp_err   <= 2'b00;
            rsp_rdata <= load_data;
          end else if (timeout_hit) begin
            rsp_err   <= 2'b10;
            rsp_rdata <= '0;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_err   <= '0;
            rsp_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
